id_operand_stage: RTL and testbench

//  Decode/operand-fetch pipeline stage immediately upstream of EX; consumes the combinational read

---
 rtl/id_operand_stage.sv | 179 +++++++++++++++++
 tb/tb_id_operand_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// ============================================================================
// Module      : id_operand_stage
// Description : Decode/operand-fetch pipeline stage that sits directly ahead of
//               EX. It reads the two combinational REGFILE16 read ports,
//               resolves read-after-write hazards and holds the resolved
//               operands, the destination and a valid flag in a single
//               valid/ready pipeline register.
//
//               Build option (macro ID_OPERAND_FWD_EN):
//                 defined   : EX and WB results are bypassed into the operands.
//                             The stage stalls only when a source depends on a
//                             load that is still in EX.
//                 undefined : operands come from the register file only. The
//                             stage stalls while any nonzero source matches a
//                             pending EX or WB write, load or not.
//               Both builds deliver identical operand values. The build
//               without forwarding has lower throughput.
//
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous reset, active-low
//               in_valid   - decode presents an instruction
//               in_ready   - instruction accepted this cycle
//               in_rs      - source A address (also REGFILE16 r_addr_reg1)
//               in_rt      - source B address (also REGFILE16 r_addr_reg2)
//               in_rd      - destination address (0 = no write)
//               in_use_rt  - instruction reads rt
//               rf_data1   - REGFILE16 r_data_reg1
//               rf_data2   - REGFILE16 r_data_reg2
//               ex_w       - EX stage will write ex_addr
//               ex_load    - EX instruction is a load
//               ex_addr    - EX destination
//               ex_data    - EX ALU result
//               wb_w       - writeback enable
//               wb_addr    - writeback address
//               wb_data    - writeback data
//               flush      - squash the held and the incoming instruction
//               out_valid  - held instruction valid toward EX
//               out_ready  - EX accepts the held instruction
//               out_a      - resolved operand A
//               out_b      - resolved operand B
//               out_rd     - held destination
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_operand_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic          in_use_rt,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic          ex_w,
  input  logic          ex_load,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_data,
  input  logic          wb_w,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_rd
);

  logic          r_valid;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [AW-1:0] r_rd;

  logic          w_hazard;
  logic          w_in_ready;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  logic w_rs_zero;
  logic w_rt_zero;
  assign w_rs_zero = (in_rs == '0);
  assign w_rt_zero = (in_rt == '0);

`ifdef ID_OPERAND_FWD_EN

  logic w_ex_fwd_a;
  logic w_ex_fwd_b;
  logic w_wb_fwd_a;
  logic w_wb_fwd_b;

  // A load in EX has no data yet, so it is excluded from the EX bypass and
  // instead creates a one-cycle load-use stall. One cycle later the loaded
  // value shows up on the WB port and is bypassed from there.
  assign w_ex_fwd_a = ex_w && !ex_load && (ex_addr == in_rs);
  assign w_ex_fwd_b = ex_w && !ex_load && (ex_addr == in_rt);
  assign w_wb_fwd_a = wb_w && (wb_addr == in_rs);
  assign w_wb_fwd_b = wb_w && (wb_addr == in_rt);

  assign w_hazard = in_valid && ex_w && ex_load && (ex_addr != '0) &&
                    ((ex_addr == in_rs) || (in_use_rt && (ex_addr == in_rt)));

  // EX is younger than WB and therefore wins. The WB bypass is needed because
  // the register file commits on the same edge that would capture rf data.
  always_comb begin
    w_a = rf_data1;
    if (w_rs_zero)       w_a = '0;
    else if (w_ex_fwd_a) w_a = ex_data;
    else if (w_wb_fwd_a) w_a = wb_data;

    w_b = rf_data2;
    if (w_rt_zero)       w_b = '0;
    else if (w_ex_fwd_b) w_b = ex_data;
    else if (w_wb_fwd_b) w_b = wb_data;
  end

`else

  logic w_dep_a;
  logic w_dep_b;
  logic w_unused_nofwd;

  // Without bypassing, wait until every pending producer of a source has
  // committed to the register file, including the WB write that lands on the
  // same edge as capture.
  assign w_dep_a = !w_rs_zero &&
                   ((ex_w && (ex_addr == in_rs)) || (wb_w && (wb_addr == in_rs)));
  assign w_dep_b = in_use_rt && !w_rt_zero &&
                   ((ex_w && (ex_addr == in_rt)) || (wb_w && (wb_addr == in_rt)));

  assign w_hazard = in_valid && (w_dep_a || w_dep_b);

  assign w_a = w_rs_zero ? '0 : rf_data1;
  assign w_b = w_rt_zero ? '0 : rf_data2;

  // Bypass data ports are part of the common interface but unused here.
  assign w_unused_nofwd = ^{ex_load, ex_data, wb_data};

`endif

  assign w_in_ready = rst_n && !w_hazard && (!r_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
    end else if (flush) begin
      // Squash both the held and the incoming instruction; data is left as-is
      // because out_valid already qualifies it.
      r_valid <= 1'b0;
    end else if (in_valid && w_in_ready) begin
      r_valid <= 1'b1;
      r_a     <= w_a;
      r_b     <= w_b;
      r_rd    <= in_rd;
    end else if (out_ready) begin
      // Held instruction drained with nothing to replace it: insert a bubble.
      r_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_rd    = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_id_operand_stage.sv
// ============================================================================
// Module      : tb_id_operand_stage
// Description : Directed bench for id_operand_stage. A small environment
//               model plays the register file and the EX/WB pipeline: every
//               cycle WB commits to the register file and EX moves into WB,
//               so a producer eventually retires and the bench works with or
//               without the forwarding build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;
  logic [AW-1:0] in_rd;
  logic          in_use_rt;
  logic [DW-1:0] rf_data1;
  logic [DW-1:0] rf_data2;
  logic          ex_w;
  logic          ex_load;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_data;
  logic [DW-1:0] ex_ld_val;
  logic          wb_w;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [AW-1:0] out_rd;

  logic [DW-1:0] rf [0:(1<<AW)-1];

  int n_checks;
  int n_errors;
  int waits;

  id_operand_stage #(.DW(DW), .AW(AW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_use_rt (in_use_rt),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .ex_w      (ex_w),
    .ex_load   (ex_load),
    .ex_addr   (ex_addr),
    .ex_data   (ex_data),
    .wb_w      (wb_w),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_rd    (out_rd)
  );

  assign rf_data1 = rf[in_rs];
  assign rf_data2 = rf[in_rt];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: wait past the edge, then advance the environment
  // (WB commits to the register file, EX moves into WB, EX empties).
  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_w && wb_addr != '0) rf[wb_addr] = wb_data;
    wb_w    = ex_w;
    wb_addr = ex_addr;
    wb_data = ex_load ? ex_ld_val : ex_data;
    ex_w    = 1'b0;
    ex_load = 1'b0;
  endtask

  // Present an instruction and keep it there until accepted (bounded).
  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic use_rt, output int nwait);
    logic acc;
    in_valid  = 1'b1;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_use_rt = use_rt;
    nwait     = 0;
    acc       = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      #1;
      acc = in_ready;
      tick();
      if (!acc) nwait++;
    end
    in_valid = 1'b0;
    check("accepted", {31'd0, acc}, 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_rs     = '0;
    in_rt     = '0;
    in_rd     = '0;
    in_use_rt = 1'b0;
    ex_w      = 1'b0;
    ex_load   = 1'b0;
    ex_addr   = '0;
    ex_data   = '0;
    ex_ld_val = '0;
    wb_w      = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < (1<<AW); i++) rf[i] = '0;
    rf[1]  = 32'h0000_0011;
    rf[10] = 32'hA5A5_0001;
    rf[11] = 32'h0000_00B2;

    // 1: reset
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 2: EX bypass, register file still holds 0 for r3
    ex_w = 1'b1; ex_addr = 5'd3; ex_data = 32'h0000_1234;
    issue(5'd3, 5'd0, 5'd9, 1'b0, waits);
    check("ex_fwd_valid", {31'd0, out_valid}, 32'd1);
    check("ex_fwd_a", out_a, 32'h0000_1234);
    check("ex_fwd_b", out_b, 32'd0);
    check("ex_fwd_rd", {27'd0, out_rd}, 32'd9);

    // 3: WB bypass plus register 0 on rt
    tick();
    check("bubble_after_drain", {31'd0, out_valid}, 32'd0);
    wb_w = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_DEAD;
    issue(5'd5, 5'd0, 5'd2, 1'b1, waits);
    check("wb_fwd_a", out_a, 32'h0000_DEAD);
    check("wb_fwd_b_zero", out_b, 32'd0);

    // EX result must win over an older WB write to the same register
    ex_w = 1'b1; ex_addr = 5'd3; ex_data = 32'h0000_2222;
    wb_w = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_1111;
    issue(5'd0, 5'd3, 5'd6, 1'b1, waits);
    check("ex_over_wb_b", out_b, 32'h0000_2222);
    check("ex_over_wb_a_zero", out_a, 32'd0);

    // No hazard: accepted without stalling, operands from the register file
    issue(5'd10, 5'd11, 5'd12, 1'b1, waits);
    check("nohaz_waits", waits, 32'd0);
    check("nohaz_a", out_a, 32'hA5A5_0001);
    check("nohaz_b", out_b, 32'h0000_00B2);
    check("nohaz_valid", {31'd0, out_valid}, 32'd1);

    // 4: load-use on rt
    ex_w = 1'b1; ex_load = 1'b1; ex_addr = 5'd7; ex_ld_val = 32'h0000_BEEF;
    in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd7; in_rd = 5'd4; in_use_rt = 1'b1;
    #1;
    check("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    issue(5'd1, 5'd7, 5'd4, 1'b1, waits);
    check("lu_valid", {31'd0, out_valid}, 32'd1);
    check("lu_a", out_a, 32'h0000_0011);
    check("lu_b", out_b, 32'h0000_BEEF);
    check("lu_rd", {27'd0, out_rd}, 32'd4);

    // 5: backpressure holds everything
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs = 5'd10; in_rt = 5'd11; in_rd = 5'd13; in_use_rt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_a", out_a, 32'h0000_0011);
      check("bp_b", out_b, 32'h0000_BEEF);
      check("bp_rd", {27'd0, out_rd}, 32'd4);
    end

    // 6: flush while stalled drops both instructions
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_data_kept", out_a, 32'h0000_0011);
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("flush_no_reload", {31'd0, out_valid}, 32'd0);

    // Reset while an instruction is held
    out_ready = 1'b1;
    issue(5'd10, 5'd11, 5'd14, 1'b1, waits);
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_a", out_a, 32'd0);
    check("midrst_b", out_b, 32'd0);
    check("midrst_rd", {27'd0, out_rd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
